mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-wide RAM arbiter that feeds the fetch stage and the MEM stage of the RISC-V pipeline.
- Serialises 32-bit instruction fetches and 8/16/32-bit data loads and stores into byte accesses on a single-port RAM with 1-cycle read latency.
- Returns busy/done status in the encoding the fetch stage consumes: busy_out[0] = fetch in flight, busy_out[1] = data access in flight.
- MEM-stage requests have priority over fetch.

Parameters:
- ADDR_W, 32, width of byte addresses on all ports.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-low (0 = reset).
- rdy  input  1  global ready; 0 freezes the block.
- if_req_in  input  1  fetch request, level, held by requester.
- if_addr_in  input  32  fetch address, word-aligned.
- branch_flag_in  input  1  pipeline flush; aborts an in-flight fetch.
- mem_req_in  input  1  data request, level.
- mem_we_in  input  1  1 = store, 0 = load.
- mem_sel_in  input  2  size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_signed_in  input  1  load sign-extend enable.
- mem_addr_in  input  32  data address.
- mem_wdata_in  input  32  store data; low bytes are used first.
- io_buffer_full  input  1  IO output buffer full.
- ram_din  input  8  RAM read byte.
- ram_dout  output  8  RAM write byte.
- ram_a  output  32  RAM byte address.
- ram_wr  output  1  RAM write strobe.
- busy_out  output  2  bit0 = fetch in flight, bit1 = data access in flight.
- inst_done_out  output  1  one-cycle pulse: inst_out is valid.
- inst_out  output  32  fetched instruction, little-endian.
- mem_done_out  output  1  one-cycle pulse: data access complete.
- mem_rdata_out  output  32  extended load data; 0 after a store.

Behaviour:
- Reset (rst_in=0 at an edge): state IDLE; all outputs 0, including ram_a, ram_wr, busy_out, done pulses and data. Reset mid-transaction discards the transaction and emits no done pulse.
- rdy=0: state, counters and outputs hold, except ram_wr, which is forced 0 for that cycle. The cycle is not counted.
- States: IDLE, FETCH, LOAD, STORE.
  - Byte counter cnt: 0..3.
  - Byte count n: fetch = 4; data = 1, 2 or 4 from mem_sel_in.
- IDLE arbitration, registered at the edge ending cycle C0:
  - mem_req_in=1 → latch request, go LOAD or STORE. This applies even when if_req_in is also 1.
  - Otherwise if_req_in=1 and branch_flag_in=0 → latch if_addr_in, go FETCH.
- Read sequence (FETCH/LOAD):
  - Cycles C1..Cn: ram_a = addr+cnt, ram_wr = 0.
  - Byte k is captured from ram_din one cycle after its address is driven.
  - Final byte is captured at the end of C(n+1). Controller returns to IDLE and pulses done in C(n+2).
  - Fetch latency is therefore 6 cycles from C0 to the inst_done_out cycle.
  - During the pulse cycle the controller is IDLE and may accept a new request at the end of that cycle.
- Write sequence (STORE):
  - Cycles C1..Cn: ram_wr = 1, ram_a = addr+cnt, ram_dout = mem_wdata_in byte cnt.
  - mem_done_out pulses in C(n+1).
- busy_out:
  - [0] = 1 in FETCH; [1] = 1 in LOAD/STORE; 00 in IDLE and in the done-pulse cycle.
  - A fetch requested while busy_out=10 is served after the data access; if_req_in stays asserted meanwhile.
- Load extension:
  - Byte or half: upper bits = sign of top byte when mem_signed_in = 1, else 0.
  - Word: unextended.
- Flush: branch_flag_in=1 in any FETCH cycle → go IDLE at that edge, ram_wr=0, no inst_done_out. LOAD and STORE ignore branch_flag_in.
- Address wrap: addr+cnt wraps modulo 2^32.
- inst_out and mem_rdata_out hold their last value between pulses.

Optional Feature:
- Macro MEM_CTRL_IO_STALL_EN.
- Defined: in STORE, if addr[17:16]==IO_ADDR_HI and io_buffer_full=1:
  - The current byte is not issued (ram_wr=0) and cnt holds, until io_buffer_full=0.
  - busy_out stays 10 throughout.
  - A second consecutive IO store is delayed by one extra idle cycle before C1.
- Not defined: io_buffer_full is ignored and IO stores proceed at normal timing.

Test Plan:
- Fetch: if_req_in=1, if_addr_in=0x100, RAM bytes 13,05,00,00 → ram_a = 0x100..0x103 in C1..C4; inst_done_out=1 in C6 with inst_out=0x00000513; busy_out=01 in C1..C5.
- Priority: if_req_in and mem_req_in (load word 0x200) both asserted in C0 → busy_out=10; mem_done_out in C6; fetch C1 starts at C7; inst_done_out at C12.
- Signed load: byte at 0x3 = 0x80, sel=0 → mem_signed_in=1 gives mem_rdata_out=0xFFFFFF80 in C3; mem_signed_in=0 gives 0x00000080.
- Store half 0xBEEF to 0x40 → ram_wr=1 with (0x40,0xEF) in C1 and (0x41,0xBE) in C2; mem_done_out in C3.
- Flush: branch_flag_in=1 in C3 of a fetch → IDLE in C4, busy_out=00, no inst_done_out; new fetch accepted in C4.
- Reset/rdy: rst_in=0 in C2 of a store → all outputs 0 next cycle. rdy=0 for 3 cycles mid-fetch → inst_done_out delayed by exactly 3 cycles and ram_wr=0 throughout.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide single-port RAM arbiter for the fetch and MEM stages.
// Serialises 32-bit fetches and 8/16/32-bit loads/stores into byte accesses
// on a RAM with one cycle of read latency. MEM requests win over fetch.
// Optional build macro: MEM_CTRL_IO_STALL_EN (stall IO-region stores while
// the IO output buffer is full; otherwise io_buffer_full is ignored).
module mem_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              branch_flag_in,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_sel_in,
  input  logic              mem_signed_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [1:0]        busy_out,
  output logic              inst_done_out,
  output logic [31:0]       inst_out,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  // Byte count of a data access from its size code; code 3 behaves as word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // step counts cycles inside a transaction: in cycle Ck it holds k-1, so it
  // is also the index of the byte currently on ram_a while step < len.
  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              inst_done_q, inst_done_d;
  logic [31:0]       inst_q, inst_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  // Read capture pipeline: which byte the RAM is returning this cycle.
  logic [3:0][7:0]   rd_buf_q, rd_merge;
  logic              rd_vld_q;
  logic [1:0]        rd_idx_q;

  logic              store_stall;  // current IO store byte must wait
  logic              io_defer;     // back-to-back IO store waits one cycle
  logic [2:0]        step_nxt;

  assign step_nxt = step_q + 3'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  logic io_gap_q;
  logic addr_is_io;
  logic req_is_io;

  assign addr_is_io  = (addr_q[17:16] == IO_ADDR_HI);
  assign req_is_io   = mem_we_in && (mem_addr_in[17:16] == IO_ADDR_HI);
  assign store_stall = (state_q == STORE) && addr_is_io && io_buffer_full;
  assign io_defer    = io_gap_q && req_is_io;

  // Flag the cycle right after an IO store completes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_gap_q <= 1'b0;
    end else if (rdy) begin
      io_gap_q <= (state_q == STORE) && addr_is_io && !store_stall &&
                  (step_nxt >= len_q);
    end
  end
`else
  logic unused_io;

  assign unused_io   = ^{io_buffer_full, IO_ADDR_HI};
  assign store_stall = 1'b0;
  assign io_defer    = 1'b0;
`endif

  // Latest read byte merged over the bytes captured so far.
  always_comb begin
    rd_merge = rd_buf_q;
    if (rd_vld_q) rd_merge[rd_idx_q] = ram_din;
  end

  // The RAM keeps reading while rdy=0, so capture tracks the address of the
  // previous cycle on every edge rather than following the frozen FSM.
  always_ff @(posedge clk_in) begin
    // NOTE: the capture buffer is reset like any other register so a partial
    // transaction cut by reset leaves no stale bytes behind.
    if (!rst_in) begin
      rd_buf_q <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= 2'd0;
    end else begin
      rd_buf_q <= rd_merge;
      rd_vld_q <= ((state_q == FETCH) || (state_q == LOAD)) && (step_q < len_q);
      rd_idx_q <= step_q[1:0];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    if (!rst_in) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      signed_q    <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      inst_done_q <= 1'b0;
      inst_q      <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      signed_q    <= signed_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      inst_done_q <= inst_done_d;
      inst_q      <= inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state and next-output logic; rdy=0 leaves everything as it is.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    step_d      = step_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    signed_d    = signed_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    inst_done_d = inst_done_q;
    inst_d      = inst_q;
    mem_done_d  = mem_done_q;
    mem_rdata_d = mem_rdata_q;

    if (rdy) begin
      inst_done_d = 1'b0;
      mem_done_d  = 1'b0;
      ram_wr_d    = 1'b0;

      case (state_q)
        IDLE: begin
          step_d = 3'd0;
          if (mem_req_in) begin
            if (!io_defer) begin
              state_d    = mem_we_in ? STORE : LOAD;
              len_d      = size_bytes(mem_sel_in);
              addr_d     = mem_addr_in;
              ram_a_d    = mem_addr_in;
              wdata_d    = mem_wdata_in;
              signed_d   = mem_signed_in;
              ram_wr_d   = mem_we_in;
              ram_dout_d = mem_we_in ? mem_wdata_in[7:0] : ram_dout_q;
            end
          end else if (if_req_in && !branch_flag_in) begin
            state_d = FETCH;
            len_d   = 3'd4;
            addr_d  = if_addr_in;
            ram_a_d = if_addr_in;
          end
        end

        FETCH, LOAD: begin
          if ((state_q == FETCH) && branch_flag_in) begin
            state_d = IDLE;
            step_d  = 3'd0;
          end else if (step_q == len_q) begin
            // Last byte is on ram_din now; finish and pulse next cycle.
            state_d = IDLE;
            step_d  = 3'd0;
            if (state_q == FETCH) begin
              inst_done_d = 1'b1;
              inst_d      = rd_merge;
            end else begin
              mem_done_d = 1'b1;
              case (len_q)
                3'd1:    mem_rdata_d = {{24{signed_q & rd_merge[0][7]}}, rd_merge[0]};
                3'd2:    mem_rdata_d = {{16{signed_q & rd_merge[1][7]}}, rd_merge[1], rd_merge[0]};
                default: mem_rdata_d = rd_merge;
              endcase
            end
          end else begin
            step_d = step_nxt;
            if (step_nxt < len_q) ram_a_d = addr_q + ADDR_W'(step_nxt);
          end
        end

        STORE: begin
          if (store_stall) begin
            ram_wr_d = ram_wr_q;
          end else if (step_nxt < len_q) begin
            step_d     = step_nxt;
            ram_a_d    = addr_q + ADDR_W'(step_nxt);
            ram_dout_d = wdata_q[{step_nxt[1:0], 3'b000} +: 8];
            ram_wr_d   = 1'b1;
          end else begin
            state_d     = IDLE;
            step_d      = 3'd0;
            mem_done_d  = 1'b1;
            mem_rdata_d = '0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign ram_a         = ram_a_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q & rdy & ~store_stall;
  assign busy_out      = {(state_q == LOAD) || (state_q == STORE), state_q == FETCH};
  assign inst_done_out = inst_done_q;
  assign inst_out      = inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;

endmodule
